mul_div_unit: RTL and testbench

Iterative multiply/divide unit fed directly by the register file's SR1_Out/SR2_Out read ports. It extends the datapath beside the single-cycle ALU. The control FSM starts an operation, holds in a wait state while Busy, and gates Result onto the bus once Done. It is multi-cycle: one operand bit per clock, radix-2.

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: one operand bit per clock, fixed WIDTH+1 cycle latency.
// Optional feature macro: SIGNED_MULDIV_EN (two's-complement operands with sign fix-up in FIN).
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, state_next;

  // MUL: acc = {partial product high, multiplier shifting out}; opnd = multiplicand.
  // DIV: acc = {partial remainder, quotient/dividend shifting}; opnd = divisor.
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   opnd, a_reg, result_reg, fin_value;
  logic [1:0]         op_reg;
  logic [CNT_W-1:0]   cnt;
  logic               dz_reg, dz_hold, sign_x, sign_a;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               sign_x_in, sign_a_in;
  logic [WIDTH:0]     sum, sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef SIGNED_MULDIV_EN
  assign a_mag     = A_In[WIDTH-1] ? -A_In : A_In;
  assign b_mag     = B_In[WIDTH-1] ? -B_In : B_In;
  assign sign_a_in = A_In[WIDTH-1];
  assign sign_x_in = A_In[WIDTH-1] ^ B_In[WIDTH-1];
`else
  assign a_mag     = A_In;
  assign b_mag     = B_In;
  assign sign_a_in = 1'b0;
  assign sign_x_in = 1'b0;
`endif

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    acc_step = acc;
    sum      = '0;
    sh       = acc[2*WIDTH-1:WIDTH-1];
    ge       = (sh >= {1'b0, opnd});
    rem_sub  = sh[WIDTH-1:0] - opnd;
    if (!op_reg[1]) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_step = {sum, acc[WIDTH-1:1]};
    end else if (ge) begin
      acc_step = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result selection, evaluated while in FIN.
  always_comb begin
    prod_fix = sign_x ? -acc : acc;
    quo_fix  = sign_x ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_reg)
      2'b00:   fin_value = prod_fix[WIDTH-1:0];
      2'b01:   fin_value = prod_fix[2*WIDTH-1:WIDTH];
      2'b10:   fin_value = dz_reg ? '1 : quo_fix;
      default: fin_value = dz_reg ? a_reg : rem_fix;
    endcase
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    Result     = result_reg;
    Div_Zero   = dz_hold;
    case (state)
      IDLE: if (Start) state_next = CALC;
      CALC: begin
        Busy = 1'b1;
        if (cnt == CNT_W'(1)) state_next = FIN;
      end
      FIN: begin
        Done       = 1'b1;
        Result     = fin_value;
        Div_Zero   = dz_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      result_reg <= '0;
      dz_hold    <= 1'b0;
      dz_reg     <= 1'b0;
      acc        <= '0;
      opnd       <= '0;
      a_reg      <= '0;
      op_reg     <= 2'b00;
      sign_x     <= 1'b0;
      sign_a     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (Start) begin
          op_reg  <= Op;
          a_reg   <= A_In;
          cnt     <= CNT_W'(WIDTH);
          dz_reg  <= Op[1] && (B_In == '0);
          dz_hold <= 1'b0;
          sign_x  <= sign_x_in;
          sign_a  <= sign_a_in;
          if (Op[1]) begin
            opnd <= b_mag;
            acc  <= {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd <= a_mag;
            acc  <= {{WIDTH{1'b0}}, b_mag};
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
        end
        FIN: begin
          result_reg <= fin_value;
          dz_hold    <= dz_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus multi-cycle corner sequences.
// Build with SIGNED_MULDIV_EN to select the signed vector table.
module tb_mul_div_unit;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [1:0]   Op;
  logic [W-1:0] A_In, B_In, Result;
  logic         Busy, Done, Div_Zero;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .A_In(A_In), .B_In(B_In), .Result(Result),
    .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic         dz;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a Start pulse; returns in cycle k+1 with inputs scrambled to prove latching.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    @(negedge Clk);
    A_In = a; B_In = b; Op = op; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A_In  = 16'h5555;
    B_In  = 16'hAAAA;
    Op    = ~op;
  endtask

  // Starting in cycle k+1: expects Busy for 16 cycles, Done at 17, then held outputs.
  task automatic finish_op(input string name, input logic [W-1:0] exp_res, input logic exp_dz);
    int bad;
    bad = 0;
    for (int c = 1; c <= W; c++) begin
      if (!(Busy === 1'b1 && Done === 1'b0)) bad++;
      @(negedge Clk);
    end
    check({name, "_timing"}, {bad[15:0], 14'd0, Busy, Done}, {16'd0, 14'd0, 1'b0, 1'b1});
    check({name, "_result"}, {16'd0, Result}, {16'd0, exp_res});
    check({name, "_divzero"}, {31'd0, Div_Zero}, {31'd0, exp_dz});
    @(negedge Clk);
    check({name, "_hold"}, {Result, 13'd0, Done, Busy, Div_Zero}, {exp_res, 13'd0, 1'b0, 1'b0, exp_dz});
  endtask

  initial begin
    int dones, done_at;

`ifdef SIGNED_MULDIV_EN
    vecs.push_back('{16'h0123, 16'h0010, 2'b00, 16'h1230, 1'b0, "mul_lo_basic"});
    vecs.push_back('{16'hFFFA, 16'h0007, 2'b00, 16'hFFD6, 1'b0, "smul_lo"});
    vecs.push_back('{16'hFFFA, 16'h0007, 2'b01, 16'hFFFF, 1'b0, "smul_hi"});
    vecs.push_back('{16'hFFF9, 16'h0002, 2'b10, 16'hFFFD, 1'b0, "sdiv_q"});
    vecs.push_back('{16'hFFF9, 16'h0002, 2'b11, 16'hFFFF, 1'b0, "sdiv_r"});
    vecs.push_back('{16'h0007, 16'hFFFE, 2'b10, 16'hFFFD, 1'b0, "sdiv_q_negb"});
    vecs.push_back('{16'h0007, 16'hFFFE, 2'b11, 16'h0001, 1'b0, "sdiv_r_negb"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 2'b00, 16'h0001, 1'b0, "smul_m1m1"});
    vecs.push_back('{16'h1234, 16'h0000, 2'b10, 16'hFFFF, 1'b1, "div0_q"});
    vecs.push_back('{16'hFFF9, 16'h0000, 2'b11, 16'hFFF9, 1'b1, "div0_r_neg"});
`else
    vecs.push_back('{16'h0123, 16'h0010, 2'b00, 16'h1230, 1'b0, "mul_lo_basic"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 2'b01, 16'hFFFE, 1'b0, "mul_hi_max"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 2'b00, 16'h0001, 1'b0, "mul_lo_max"});
    vecs.push_back('{16'h8000, 16'h0002, 2'b01, 16'h0001, 1'b0, "mul_hi_carry"});
    vecs.push_back('{16'h00FF, 16'h0101, 2'b00, 16'hFFFF, 1'b0, "mul_lo_ff"});
    vecs.push_back('{16'd100,  16'd7,    2'b10, 16'h000E, 1'b0, "div_q"});
    vecs.push_back('{16'd100,  16'd7,    2'b11, 16'h0002, 1'b0, "div_r"});
    vecs.push_back('{16'hFFFF, 16'h0001, 2'b10, 16'hFFFF, 1'b0, "div_by_one"});
    vecs.push_back('{16'h0005, 16'h0009, 2'b10, 16'h0000, 1'b0, "div_small_q"});
    vecs.push_back('{16'h0005, 16'h0009, 2'b11, 16'h0005, 1'b0, "div_small_r"});
    vecs.push_back('{16'h1234, 16'h0000, 2'b10, 16'hFFFF, 1'b1, "div0_q"});
    vecs.push_back('{16'h1234, 16'h0000, 2'b11, 16'h1234, 1'b1, "div0_r"});
`endif

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A_In = '0; B_In = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("reset_state", {Result, 13'd0, Busy, Done, Div_Zero}, 32'd0);

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].op);
      finish_op(vecs[i].name, vecs[i].res, vecs[i].dz);
    end

    // Divide-by-zero flag holds, then clears on the next accepted Start.
    launch(16'h1234, 16'h0000, 2'b11);
    finish_op("dz_seq", 16'h1234, 1'b1);
    launch(16'h0003, 16'h0005, 2'b00);
    check("dz_clear_on_start", {30'd0, Div_Zero, Busy}, {30'd0, 1'b0, 1'b1});
    finish_op("dz_seq_mul", 16'h000F, 1'b0);

    // Start while Busy (cycle 5) is ignored: exactly one Done, at cycle 17.
    launch(16'h0003, 16'h0005, 2'b00);
    dones = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (Done === 1'b1) begin dones++; done_at = c; end
      if (c == 5) begin Start = 1'b1; A_In = 16'h7777; B_In = 16'h0002; Op = 2'b10; end
      if (c == 6) Start = 1'b0;
      if (c == 17) check("busy_start_result", {16'd0, Result}, 32'h0000_000F);
      @(negedge Clk);
    end
    check("busy_start_single_done", {dones[15:0], done_at[15:0]}, {16'd1, 16'd17});

    // Start in the Done cycle is ignored.
    launch(16'h0002, 16'h0003, 2'b00);
    repeat (W) @(negedge Clk);
    check("done_cycle_pre", {15'd0, Done, Result}, {15'd0, 1'b1, 16'h0006});
    Start = 1'b1; A_In = 16'h0009; B_In = 16'h0009; Op = 2'b00;
    @(negedge Clk);
    Start = 1'b0;
    check("start_in_done_ignored", {14'd0, Busy, Done, Result}, {14'd0, 1'b0, 1'b0, 16'h0006});

    // Reset mid-operation aborts it with no Done.
    launch(16'h0004, 16'h0004, 2'b00);
    repeat (7) @(negedge Clk);
    Reset = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    check("abort_reset_state", {Result, 13'd0, Busy, Done, Div_Zero}, 32'd0);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (Done === 1'b1) dones++;
      @(negedge Clk);
    end
    check("abort_no_done", dones, 32'd0);

    // Unit still operates normally after the abort.
    launch(16'h0123, 16'h0010, 2'b00);
    finish_op("post_abort", 16'h1230, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
